// File: rtl/cb_pkg.sv
// Shared definitions for the code-block segmenter and CRC attach stages.
package cb_pkg;

   localparam int K_LARGE = 6144;
   localparam int K_SMALL = 1056;
   localparam int CRC_LEN = 24;
   localparam int CNT_W   = 13;

   localparam logic [23:0] CRC24B_POLY = 24'h800063;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_CRCOUT = 2'd2
   } cb_state_e;

   // One serial MSB-first CRC24B step with data bit d.
   function automatic logic [23:0] crc24b_step(input logic [23:0] r, input logic d);
      logic fb;
      fb = r[23] ^ d;
      return {r[22:0], 1'b0} ^ (fb ? CRC24B_POLY : 24'h000000);
   endfunction

endpackage

// File: rtl/crc24b_serial.sv
// Serial CRC24B register: absorb a bit, or shift the remainder out MSB first.
import cb_pkg::*;

module crc24b_serial (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   input  logic shift_out,
   input  logic d,
   output logic msb
);

   logic [23:0] r;

   // clr together with en restarts the CRC and absorbs d in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r <= '0;
      end else if (en) begin
         r <= crc24b_step(clr ? 24'h000000 : r, d);
      end else if (shift_out) begin
         r <= {r[22:0], 1'b0};
      end else if (clr) begin
         r <= '0;
      end
   end

   assign msb = r[23];

endmodule

// File: rtl/cb_crc_attach.sv
// Code-block CRC24B attach: re-emits each block one cycle late with the
// trailing CRC window filled by the computed CRC, and checks length.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no block in progress, waiting for start
// ST_DATA   | payload/filler bits, CRC absorbing data
// ST_CRCOUT | CRC window, remainder shifted out MSB first
import cb_pkg::*;

module cb_crc_attach #(
   parameter int K_LARGE = cb_pkg::K_LARGE,
   parameter int K_SMALL = cb_pkg::K_SMALL,
   parameter int CRC_LEN = cb_pkg::CRC_LEN
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic cb_size,
   input  logic cb_data,
   input  logic filling,
   input  logic crc,
   output logic out_start,
   output logic out_size,
   output logic out_valid,
   output logic out_data,
   output logic out_filling,
   output logic blk_done,
   output logic blk_ok,
   output logic len_err
);

   cb_state_e        state;
   logic [CNT_W-1:0] cnt;      // index from the end of the bit arriving this cycle
   logic             bad;      // current block already failed a length check

   logic             active;
   logic [CNT_W-1:0] k_m1;
   logic [CNT_W-1:0] cur_idx;
   logic             d_in;
   logic             crc_shift;
   logic             crc_en;
   logic             crc_clr;
   logic             crc_msb;

   // Per-cycle control derived from the current input bit and state.
   always_comb begin
      active    = start || (state != ST_IDLE);
      k_m1      = cb_size ? CNT_W'(K_LARGE - 1) : CNT_W'(K_SMALL - 1);
      cur_idx   = start ? k_m1 : cnt;
      d_in      = filling ? 1'b0 : cb_data;
      crc_shift = !start && crc && (state != ST_IDLE);
      crc_en    = start || ((state == ST_DATA) && !crc);
      crc_clr   = start;
   end

   crc24b_serial u_crc (
      .clk       (clk),
      .reset     (reset),
      .clr       (crc_clr),
      .en        (crc_en),
      .shift_out (crc_shift),
      .d         (d_in),
      .msb       (crc_msb)
   );

   // Block sequencing, length checks and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         bad         <= 1'b0;
         out_start   <= 1'b0;
         out_size    <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= 1'b0;
         out_filling <= 1'b0;
         blk_done    <= 1'b0;
         blk_ok      <= 1'b0;
         len_err     <= 1'b0;
      end else begin
         out_start   <= start;
         out_filling <= filling;
         out_valid   <= active;
         out_data    <= crc_shift ? crc_msb : (active & d_in);
         blk_done    <= 1'b0;
         blk_ok      <= 1'b0;

         if (start) begin
            // A start inside a block aborts it; the new block begins now.
            if (state != ST_IDLE) begin
               blk_done <= 1'b1;
               len_err  <= 1'b1;
            end
            // A CRC window cannot begin on the very first bit.
            if (crc) begin
               len_err <= 1'b1;
            end
            out_size <= cb_size;
            state    <= ST_DATA;
            cnt      <= cur_idx - CNT_W'(1);
            bad      <= crc;
         end else begin
            case (state)
               ST_IDLE: begin
               end
               ST_DATA: begin
                  if (cnt == '0) begin
                     // Block ran out without a proper CRC window.
                     blk_done <= 1'b1;
                     len_err  <= 1'b1;
                     state    <= ST_IDLE;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                     if (crc) begin
                        state <= ST_CRCOUT;
                        if (cnt != CNT_W'(CRC_LEN - 1)) begin
                           bad     <= 1'b1;
                           len_err <= 1'b1;
                        end
                     end
                  end
               end
               ST_CRCOUT: begin
                  if (cnt == '0) begin
                     blk_done <= 1'b1;
                     blk_ok   <= !bad && crc;
                     if (!crc) begin
                        len_err <= 1'b1;
                     end
                     state <= ST_IDLE;
                  end else if (!crc) begin
                     // Window closed early: abandon the block.
                     blk_done <= 1'b1;
                     len_err  <= 1'b1;
                     state    <= ST_IDLE;
                     cnt      <= '0;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule
